// File: rtl/sprite_compositor.sv
// sprite_compositor: multi-object rectangle compositor for the pong SoC.
// CPU writes object attributes into shadow registers. Frame start commits
// them to the active set. A two-stage pipeline (hit test, then priority and
// colour) turns the VGA counters into rgb_out. Collisions between object 0
// and every other object are accumulated over each frame.
module sprite_compositor #(
  parameter int          NUM_OBJ  = 4,
  parameter int          IDX_W    = 4,
  parameter int          COORD_W  = 12,
  parameter int          CNT_W    = 14,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic               pxClk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   hCntr,
  input  logic [CNT_W-1:0]   vCntr,
  input  logic               frame_start,
  input  logic               obj_wr_en,
  input  logic [IDX_W-1:0]   obj_wr_idx,
  input  logic [COORD_W-1:0] obj_wr_x,
  input  logic [COORD_W-1:0] obj_wr_y,
  input  logic [COORD_W-1:0] obj_wr_w,
  input  logic [COORD_W-1:0] obj_wr_h,
  input  logic [11:0]        obj_wr_color,
  input  logic               obj_wr_vis,
  output logic [11:0]        rgb_out,
  output logic               hit_valid,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [NUM_OBJ-1:0] collide,
  output logic               collide_valid
);

  // Right/bottom edges need one extra bit so x+w never wraps; comparisons
  // are done at a width that holds both that sum and the counters.
  localparam int SUM_W = COORD_W + 1;
  localparam int CMP_W = (CNT_W > SUM_W) ? CNT_W : SUM_W;
  localparam logic [IDX_W:0] NUM_OBJ_L = (IDX_W+1)'(NUM_OBJ);

  logic [COORD_W-1:0] r_sh_x   [NUM_OBJ];
  logic [COORD_W-1:0] r_sh_y   [NUM_OBJ];
  logic [COORD_W-1:0] r_sh_w   [NUM_OBJ];
  logic [COORD_W-1:0] r_sh_h   [NUM_OBJ];
  logic [11:0]        r_sh_col [NUM_OBJ];
  logic [NUM_OBJ-1:0] r_sh_vis;

  logic [COORD_W-1:0] r_ac_x   [NUM_OBJ];
  logic [COORD_W-1:0] r_ac_y   [NUM_OBJ];
  logic [COORD_W-1:0] r_ac_w   [NUM_OBJ];
  logic [COORD_W-1:0] r_ac_h   [NUM_OBJ];
  logic [11:0]        r_ac_col [NUM_OBJ];
  logic [NUM_OBJ-1:0] r_ac_vis;

  logic [NUM_OBJ-1:0] w_hit;
  logic [NUM_OBJ-1:0] r_hit_p1;
  logic [11:0]        r_col_p1 [NUM_OBJ];

  logic               w_win_vld;
  logic [IDX_W-1:0]   w_win_idx;
  logic [11:0]        w_win_col;

  logic [NUM_OBJ-1:0] w_coll_set;
  logic [NUM_OBJ-1:0] r_acc;

  logic               w_wr_ok;
  assign w_wr_ok = obj_wr_en && ({1'b0, obj_wr_idx} < NUM_OBJ_L);

  // Shadow register file: CPU writes land here, out-of-range indices dropped.
  always_ff @(posedge pxClk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_sh_x[k]   <= '0;
        r_sh_y[k]   <= '0;
        r_sh_w[k]   <= '0;
        r_sh_h[k]   <= '0;
        r_sh_col[k] <= '0;
      end
      r_sh_vis <= '0;
    end else if (w_wr_ok) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        if (obj_wr_idx == IDX_W'(k)) begin
          r_sh_x[k]   <= obj_wr_x;
          r_sh_y[k]   <= obj_wr_y;
          r_sh_w[k]   <= obj_wr_w;
          r_sh_h[k]   <= obj_wr_h;
          r_sh_col[k] <= obj_wr_color;
          r_sh_vis[k] <= obj_wr_vis;
        end
      end
    end
  end

  // Active register file: copied from the pre-edge shadow only at frame start.
  always_ff @(posedge pxClk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_ac_x[k]   <= '0;
        r_ac_y[k]   <= '0;
        r_ac_w[k]   <= '0;
        r_ac_h[k]   <= '0;
        r_ac_col[k] <= '0;
      end
      r_ac_vis <= '0;
    end else if (frame_start) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_ac_x[k]   <= r_sh_x[k];
        r_ac_y[k]   <= r_sh_y[k];
        r_ac_w[k]   <= r_sh_w[k];
        r_ac_h[k]   <= r_sh_h[k];
        r_ac_col[k] <= r_sh_col[k];
      end
      r_ac_vis <= r_sh_vis;
    end
  end

  // Per-object rectangle test against the current counters.
  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
    logic [SUM_W-1:0] w_xe;
    logic [SUM_W-1:0] w_ye;
    assign w_xe = {1'b0, r_ac_x[g]} + {1'b0, r_ac_w[g]};
    assign w_ye = {1'b0, r_ac_y[g]} + {1'b0, r_ac_h[g]};
    assign w_hit[g] = r_ac_vis[g] && (r_ac_w[g] != '0) && (r_ac_h[g] != '0) &&
                      (CMP_W'(hCntr) >= CMP_W'(r_ac_x[g])) && (CMP_W'(hCntr) < CMP_W'(w_xe)) &&
                      (CMP_W'(vCntr) >= CMP_W'(r_ac_y[g])) && (CMP_W'(vCntr) < CMP_W'(w_ye));
  end

  // ---- stage 1: register hit vector with the colours it was tested against
  always_ff @(posedge pxClk or negedge rst) begin
    if (!rst) begin
      r_hit_p1 <= '0;
      for (int k = 0; k < NUM_OBJ; k++) r_col_p1[k] <= '0;
    end else begin
      r_hit_p1 <= w_hit;
      for (int k = 0; k < NUM_OBJ; k++) r_col_p1[k] <= r_ac_col[k];
    end
  end

  // Fixed priority: scanning down so the lowest-index hit is the last to win.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_win_col = BG_COLOR;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      if (r_hit_p1[k]) begin
        w_win_vld = 1'b1;
        w_win_idx = IDX_W'(k);
        w_win_col = r_col_p1[k];
      end
    end
  end

  // ---- stage 2: registered composited output
  always_ff @(posedge pxClk or negedge rst) begin
    if (!rst) begin
      rgb_out   <= BG_COLOR;
      hit_valid <= 1'b0;
      hit_idx   <= '0;
    end else begin
      rgb_out   <= w_win_col;
      hit_valid <= w_win_vld;
      hit_idx   <= w_win_idx;
    end
  end

  // Ball (object 0) against every other object; bit 0 can never set.
  assign w_coll_set = r_hit_p1[0] ? {r_hit_p1[NUM_OBJ-1:1], 1'b0} : '0;

  // Sticky per-frame collision accumulator, latched and cleared at frame start.
  always_ff @(posedge pxClk or negedge rst) begin
    if (!rst) begin
      r_acc         <= '0;
      collide       <= '0;
      collide_valid <= 1'b0;
    end else if (frame_start) begin
      collide       <= r_acc | w_coll_set;
      r_acc         <= '0;
      collide_valid <= 1'b1;
    end else begin
      r_acc         <= r_acc | w_coll_set;
      collide_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: vector table per phase plus
// hand-written sequences for commit timing, collisions and reset.
module tb_sprite_compositor;

  localparam int NUM_OBJ = 4;
  localparam int IDX_W   = 4;
  localparam int COORD_W = 12;
  localparam int CNT_W   = 14;

  logic               pxClk;
  logic               rst;
  logic [CNT_W-1:0]   hCntr, vCntr;
  logic               frame_start;
  logic               obj_wr_en;
  logic [IDX_W-1:0]   obj_wr_idx;
  logic [COORD_W-1:0] obj_wr_x, obj_wr_y, obj_wr_w, obj_wr_h;
  logic [11:0]        obj_wr_color;
  logic               obj_wr_vis;
  logic [11:0]        rgb_out;
  logic               hit_valid;
  logic [IDX_W-1:0]   hit_idx;
  logic [NUM_OBJ-1:0] collide;
  logic               collide_valid;

  sprite_compositor #(
    .NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W), .COORD_W(COORD_W), .CNT_W(CNT_W), .BG_COLOR(12'h000)
  ) dut (
    .pxClk(pxClk), .rst(rst), .hCntr(hCntr), .vCntr(vCntr), .frame_start(frame_start),
    .obj_wr_en(obj_wr_en), .obj_wr_idx(obj_wr_idx), .obj_wr_x(obj_wr_x), .obj_wr_y(obj_wr_y),
    .obj_wr_w(obj_wr_w), .obj_wr_h(obj_wr_h), .obj_wr_color(obj_wr_color), .obj_wr_vis(obj_wr_vis),
    .rgb_out(rgb_out), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .collide(collide), .collide_valid(collide_valid)
  );

  initial begin
    pxClk = 1'b0;
    forever #5 pxClk = ~pxClk;
  end

  typedef struct {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic [11:0]      rgb;
    logic             vld;
    logic [IDX_W-1:0] idx;
  } vec_t;

  vec_t tbl[$];
  int   ph_start[11];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic add(input int h, input int v, input int rgb, input int vld, input int idx);
    vec_t e;
    e.h = CNT_W'(h); e.v = CNT_W'(v); e.rgb = 12'(rgb); e.vld = 1'(vld); e.idx = IDX_W'(idx);
    tbl.push_back(e);
  endtask

  // Drive one counter pair and compare the output two edges later.
  task automatic run_phase(input int ph);
    for (int i = ph_start[ph]; i < ph_start[ph+1]; i++) begin
      @(negedge pxClk);
      hCntr = tbl[i].h; vCntr = tbl[i].v;
      @(posedge pxClk); @(posedge pxClk); #1;
      chk($sformatf("p%0d_v%0d_rgb", ph, i), 32'(rgb_out), 32'(tbl[i].rgb));
      chk($sformatf("p%0d_v%0d_vld", ph, i), 32'(hit_valid), 32'(tbl[i].vld));
      chk($sformatf("p%0d_v%0d_idx", ph, i), 32'(hit_idx), 32'(tbl[i].idx));
    end
  endtask

  task automatic park();
    @(negedge pxClk);
    hCntr = 14'd16383; vCntr = 14'd16383;
    repeat (3) @(posedge pxClk);
  endtask

  task automatic wr(input int idx, input int x, input int y, input int w, input int h,
                    input int col, input int vis, input int fs);
    @(negedge pxClk);
    obj_wr_en = 1'b1; obj_wr_idx = IDX_W'(idx);
    obj_wr_x = COORD_W'(x); obj_wr_y = COORD_W'(y); obj_wr_w = COORD_W'(w); obj_wr_h = COORD_W'(h);
    obj_wr_color = 12'(col); obj_wr_vis = 1'(vis); frame_start = 1'(fs);
    @(posedge pxClk);
    @(negedge pxClk);
    obj_wr_en = 1'b0; frame_start = 1'b0;
  endtask

  task automatic fs_check(input string nm, input int exp);
    park();
    @(negedge pxClk); frame_start = 1'b1;
    @(posedge pxClk); #1;
    chk({nm, "_cv"}, 32'(collide_valid), 32'd1);
    chk({nm, "_col"}, 32'(collide), 32'(exp));
    @(negedge pxClk); frame_start = 1'b0;
    @(posedge pxClk); #1;
    chk({nm, "_cv_off"}, 32'(collide_valid), 32'd0);
    chk({nm, "_col_hold"}, 32'(collide), 32'(exp));
  endtask

  initial begin
    // phase 0: nothing committed
    ph_start[0] = tbl.size();
    add(0, 0, 0, 0, 0); add(20, 100, 0, 0, 0); add(639, 479, 0, 0, 0);
    add(4095, 10, 0, 0, 0); add(16383, 16383, 0, 0, 0);
    // phase 1: obj1 only
    ph_start[1] = tbl.size();
    add(20, 100, 'hFFF, 1, 1); add(39, 259, 'hFFF, 1, 1); add(40, 100, 0, 0, 0);
    add(20, 260, 0, 0, 0); add(19, 100, 0, 0, 0); add(20, 99, 0, 0, 0);
    // phase 2: obj0 over obj1
    ph_start[2] = tbl.size();
    add(30, 110, 'hF00, 1, 0); add(35, 120, 'hF00, 1, 0); add(59, 139, 'hF00, 1, 0);
    add(25, 120, 'hFFF, 1, 1); add(60, 110, 0, 0, 0); add(30, 140, 'hFFF, 1, 1);
    // phase 3: obj1 moved in shadow only
    ph_start[3] = tbl.size();
    add(20, 100, 'hFFF, 1, 1); add(500, 100, 0, 0, 0);
    // phase 4: move committed
    ph_start[4] = tbl.size();
    add(20, 100, 0, 0, 0); add(500, 100, 'hFFF, 1, 1); add(519, 259, 'hFFF, 1, 1);
    add(30, 110, 'hF00, 1, 0);
    // phase 5: write coinciding with frame_start not yet visible
    ph_start[5] = tbl.size();
    add(500, 100, 'hFFF, 1, 1); add(700, 100, 0, 0, 0);
    // phase 6: visible one frame later
    ph_start[6] = tbl.size();
    add(700, 100, 'hFFF, 1, 1); add(500, 100, 0, 0, 0);
    // phase 7: right-edge object, zero-width object, ignored index
    ph_start[7] = tbl.size();
    add(4090, 10, 'h0F0, 1, 2); add(4109, 49, 'h0F0, 1, 2); add(4110, 10, 0, 0, 0);
    add(0, 10, 0, 0, 0); add(13, 10, 0, 0, 0); add(0, 0, 0, 0, 0);
    add(50, 50, 0, 0, 0); add(4090, 50, 0, 0, 0);
    // phase 8: after mid-line reset
    ph_start[8] = tbl.size();
    add(4095, 10, 0, 0, 0); add(900, 100, 0, 0, 0); add(30, 110, 0, 0, 0);
    // phase 9: obj2 rewritten and committed
    ph_start[9] = tbl.size();
    add(4095, 10, 'h0F0, 1, 2); add(30, 110, 0, 0, 0); add(900, 100, 0, 0, 0);
    ph_start[10] = tbl.size();

    rst = 1'b0; hCntr = '0; vCntr = '0; frame_start = 1'b0; obj_wr_en = 1'b0;
    obj_wr_idx = '0; obj_wr_x = '0; obj_wr_y = '0; obj_wr_w = '0; obj_wr_h = '0;
    obj_wr_color = '0; obj_wr_vis = 1'b0;

    #12;
    chk("rst_rgb", 32'(rgb_out), 32'h000);
    chk("rst_vld", 32'(hit_valid), 32'd0);
    chk("rst_idx", 32'(hit_idx), 32'd0);
    chk("rst_col", 32'(collide), 32'd0);
    chk("rst_cv", 32'(collide_valid), 32'd0);
    @(negedge pxClk); rst = 1'b1;

    run_phase(0);
    fs_check("fs_empty", 0);

    wr(1, 20, 100, 20, 160, 'hFFF, 1, 0);
    fs_check("fs_obj1", 0);
    run_phase(1);

    wr(0, 30, 110, 30, 30, 'hF00, 1, 0);
    fs_check("fs_obj0", 0);
    run_phase(2);

    // Back-to-back frame_start: first latches the overlap, second an empty frame.
    park();
    @(negedge pxClk); frame_start = 1'b1;
    @(posedge pxClk); #1;
    chk("b2b1_cv", 32'(collide_valid), 32'd1);
    chk("b2b1_col", 32'(collide), 32'b0010);
    @(posedge pxClk); #1;
    chk("b2b2_cv", 32'(collide_valid), 32'd1);
    chk("b2b2_col", 32'(collide), 32'b0000);
    @(negedge pxClk); frame_start = 1'b0;
    @(posedge pxClk); #1;
    chk("b2b_cv_off", 32'(collide_valid), 32'd0);

    wr(1, 500, 100, 20, 160, 'hFFF, 1, 0);
    run_phase(3);
    fs_check("fs_move", 0);
    run_phase(4);
    wr(1, 700, 100, 20, 160, 'hFFF, 1, 1);
    run_phase(5);
    fs_check("fs_late", 0);
    run_phase(6);

    // Commit while pixels are in flight: old pixel keeps old attributes.
    wr(1, 900, 100, 20, 160, 'hFFF, 1, 0);
    @(negedge pxClk); hCntr = 14'd700; vCntr = 14'd100; frame_start = 1'b1;
    @(posedge pxClk); #1;
    chk("pipe_cv", 32'(collide_valid), 32'd1);
    @(negedge pxClk); hCntr = 14'd900; frame_start = 1'b0;
    @(posedge pxClk); #1;
    chk("pipe_old_rgb", 32'(rgb_out), 32'hFFF);
    chk("pipe_old_idx", 32'(hit_idx), 32'd1);
    @(negedge pxClk); hCntr = 14'd700;
    @(posedge pxClk); #1;
    chk("pipe_new_rgb", 32'(rgb_out), 32'hFFF);
    @(posedge pxClk); #1;
    chk("pipe_gone_rgb", 32'(rgb_out), 32'h000);
    chk("pipe_gone_vld", 32'(hit_valid), 32'd0);

    wr(2, 4090, 0, 20, 50, 'h0F0, 1, 0);
    wr(3, 0, 0, 0, 50, 'h00F, 1, 0);
    wr(4, 0, 0, 100, 100, 'hABC, 1, 0);
    fs_check("fs_edge", 0);
    run_phase(7);

    // Asynchronous reset between clock edges.
    @(negedge pxClk); hCntr = 14'd4095; vCntr = 14'd10;
    @(posedge pxClk); @(posedge pxClk); #1;
    chk("pre_rst_vld", 32'(hit_valid), 32'd1);
    @(posedge pxClk); #2;
    rst = 1'b0;
    #1;
    chk("arst_rgb", 32'(rgb_out), 32'h000);
    chk("arst_vld", 32'(hit_valid), 32'd0);
    chk("arst_idx", 32'(hit_idx), 32'd0);
    @(negedge pxClk); rst = 1'b1;
    run_phase(8);
    fs_check("fs_after_rst", 0);
    run_phase(8);
    wr(2, 4090, 0, 20, 50, 'h0F0, 1, 0);
    fs_check("fs_rewrite", 0);
    run_phase(9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
